// File: rtl/seg7_scan_driver_if.sv
// Bus bundle for the 7-segment scan driver: the write side and the pin side.
interface seg7_scan_driver_if;
   logic        data_we;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic [7:0]  blank_mask;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [7:0]  an_out;
   logic        frame_done;

   modport master (
      output data_we, data_in, dp_in, blank_mask,
      input  seg_out, dp_out, an_out, frame_done
   );

   modport slave (
      input  data_we, data_in, dp_in, blank_mask,
      output seg_out, dp_out, an_out, frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver. A prescaler sets the slot length,
// each slot opens with a short dark gap against ghosting, and new content is
// staged in a pending register and only swapped in at the frame boundary.
module seg7_scan_driver #(
   parameter int CLK_DIV    = 100_000,
   parameter int GAP        = 16,
   parameter int ACTIVE_LOW = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   seg7_scan_driver_if.slave bus
);

   localparam int   CW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic          run;
   logic [31:0]   pend_data, disp_data;
   logic [7:0]    pend_dp, disp_dp;
   logic [7:0]    pend_blank, disp_blank;
   logic          pend_flag;

   logic          tick;
   logic          frame_tick;
   logic          lit;
   logic [3:0]    nib;
   logic [6:0]    seg_hex;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;
   logic [7:0]    an_nxt;

   assign tick       = (cnt == CW'(CLK_DIV - 1));
   assign frame_tick = tick && (idx == 3'd7);

   // Slot prescaler: counts 0..CLK_DIV-1, the wrap cycle is the tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Digit index; starts at 7 so the first tick lands on digit 0. run keeps
   // the display dark until that first tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= 3'd7;
         run <= 1'b0;
      end else if (tick) begin
         idx <= idx + 3'd1;
         run <= 1'b1;
      end
   end

   // Pending stage: a write always wins over the clear at the frame tick, so a
   // coincident write stays pending for the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_flag  <= 1'b0;
      end else if (bus.data_we) begin
         pend_data  <= bus.data_in;
         pend_dp    <= bus.dp_in;
         pend_blank <= bus.blank_mask;
         pend_flag  <= 1'b1;
      end else if (frame_tick) begin
         pend_flag  <= 1'b0;
      end
   end

   // Display register only changes at the 7->0 tick, using the pre-write pending value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_data  <= '0;
         disp_dp    <= '0;
         disp_blank <= '0;
      end else if (frame_tick && pend_flag) begin
         disp_data  <= pend_data;
         disp_dp    <= pend_dp;
         disp_blank <= pend_blank;
      end
   end

   // Hex decode of the current digit's nibble, active-high g..a.
   always_comb begin
      nib = disp_data[{idx, 2'b00} +: 4];
      case (nib)
         4'h0:    seg_hex = 7'h3F;
         4'h1:    seg_hex = 7'h06;
         4'h2:    seg_hex = 7'h5B;
         4'h3:    seg_hex = 7'h4F;
         4'h4:    seg_hex = 7'h66;
         4'h5:    seg_hex = 7'h6D;
         4'h6:    seg_hex = 7'h7D;
         4'h7:    seg_hex = 7'h07;
         4'h8:    seg_hex = 7'h7F;
         4'h9:    seg_hex = 7'h6F;
         4'hA:    seg_hex = 7'h77;
         4'hB:    seg_hex = 7'h7C;
         4'hC:    seg_hex = 7'h39;
         4'hD:    seg_hex = 7'h5E;
         4'hE:    seg_hex = 7'h79;
         default: seg_hex = 7'h71;
      endcase
   end

   // Digit is lit once the gap has elapsed, unless masked or not yet started.
   always_comb begin
      lit     = run && (cnt >= CW'(GAP)) && !disp_blank[idx];
      seg_nxt = lit ? seg_hex : 7'h00;
      dp_nxt  = lit && disp_dp[idx];
      an_nxt  = lit ? (8'b1 << idx) : 8'h00;
   end

   // Registered pins; reset drives every pin to its inactive level at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.seg_out    <= {7{POL}};
         bus.dp_out     <= POL;
         bus.an_out     <= {8{POL}};
         bus.frame_done <= 1'b0;
      end else begin
         bus.seg_out    <= seg_nxt ^ {7{POL}};
         bus.dp_out     <= dp_nxt ^ POL;
         bus.an_out     <= an_nxt ^ {8{POL}};
         bus.frame_done <= frame_tick;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (CLK_DIV=8, GAP=2, active-high pins).
// Expected frame contents are queued when writes are issued and popped as
// each displayed frame is walked cycle by cycle.
module tb_seg7_scan_driver;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  dp;
      logic [7:0]  bl;
   } frame_t;

   typedef struct {
      int     at;
      frame_t v;
   } wr_t;

   logic clk;
   logic rst_n;
   seg7_scan_driver_if bus ();

   int n_cmp = 0;
   int n_mis = 0;
   frame_t exp_q[$];

   seg7_scan_driver #(.CLK_DIV(8), .GAP(2), .ACTIVE_LOW(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic wait_frame(input int bound, output int n);
      n = 0;
      while (bus.frame_done !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("frame_done_timeout", {31'd0, bus.frame_done}, 32'd1);
   endtask

   // Entered at the negedge where frame_done is high; walks one frame and
   // returns at the next frame_done negedge.
   task automatic check_frame(input wr_t w1, input wr_t w2);
      frame_t e;
      int k, c;
      logic on;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         e = '{d: 32'd0, dp: 8'd0, bl: 8'd0};
      end else begin
         e = exp_q.pop_front();
      end
      for (int i = 0; i <= 64; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 64) begin
            chk("frame_period", {31'd0, bus.frame_done}, 32'd1);
         end else if (i > 0) begin
            k  = (i - 1) / 8;
            c  = (i - 1) % 8;
            on = (c >= 2) && !e.bl[k];
            chk($sformatf("an_d%0d_c%0d", k, c), {24'd0, bus.an_out},
                on ? (32'd1 << k) : 32'd0);
            chk($sformatf("seg_d%0d_c%0d", k, c), {25'd0, bus.seg_out},
                on ? {25'd0, hex7(e.d[4*k +: 4])} : 32'd0);
            chk($sformatf("dp_d%0d_c%0d", k, c), {31'd0, bus.dp_out},
                {31'd0, on && e.dp[k]});
            chk($sformatf("fd_c%0d", i), {31'd0, bus.frame_done}, 32'd0);
         end
         if (w1.at == i) begin
            bus.data_we = 1'b1; bus.data_in = w1.v.d; bus.dp_in = w1.v.dp; bus.blank_mask = w1.v.bl;
         end else if (w2.at == i) begin
            bus.data_we = 1'b1; bus.data_in = w2.v.d; bus.dp_in = w2.v.dp; bus.blank_mask = w2.v.bl;
         end else begin
            bus.data_we = 1'b0;
         end
      end
      bus.data_we = 1'b0;
   endtask

   initial begin
      frame_t z, w_hex, w_blk, p, q, r;
      wr_t none, wr;
      int n;
      z     = '{d: 32'h0000_0000, dp: 8'h00, bl: 8'h00};
      w_hex = '{d: 32'h89AB_CDEF, dp: 8'h00, bl: 8'h00};
      w_blk = '{d: 32'h89AB_CDEF, dp: 8'h10, bl: 8'h0F};
      p     = '{d: 32'h0123_4567, dp: 8'h81, bl: 8'h00};
      q     = '{d: 32'h7654_3210, dp: 8'h02, bl: 8'h80};
      r     = '{d: 32'hDEAD_BEEF, dp: 8'hFF, bl: 8'h00};
      none  = '{at: -1, v: z};

      rst_n = 1'b0;
      bus.data_we = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.blank_mask = '0;
      repeat (3) @(negedge clk);
      chk("rst_an",  {24'd0, bus.an_out}, 32'd0);
      chk("rst_seg", {25'd0, bus.seg_out}, 32'd0);
      chk("rst_dp",  {31'd0, bus.dp_out}, 32'd0);
      chk("rst_fd",  {31'd0, bus.frame_done}, 32'd0);
      rst_n = 1'b1;

      wait_frame(100, n);
      chk("first_frame_latency", n, 32'd8);

      exp_q.push_back(z);
      check_frame(none, none);

      // mid-frame write: no change until the boundary
      exp_q.push_back(z);
      wr = '{at: 20, v: w_hex};
      exp_q.push_back(w_hex);
      check_frame(wr, none);

      wr = '{at: 20, v: w_blk};
      exp_q.push_back(w_blk);
      check_frame(wr, none);

      // P pending, then Q written on the 7->0 tick cycle
      exp_q.push_back(p);
      exp_q.push_back(q);
      check_frame('{at: 20, v: p}, '{at: 63, v: q});
      check_frame(none, none);
      check_frame(none, none);

      // write R, then reset during digit 5 before it can be shown
      repeat (10) @(negedge clk);
      bus.data_we = 1'b1; bus.data_in = r.d; bus.dp_in = r.dp; bus.blank_mask = r.bl;
      @(negedge clk);
      bus.data_we = 1'b0;
      repeat (34) @(negedge clk);
      chk("pre_rst_an", {24'd0, bus.an_out}, 32'h20);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_an",  {24'd0, bus.an_out}, 32'd0);
      chk("rst_async_seg", {25'd0, bus.seg_out}, 32'd0);
      chk("rst_async_dp",  {31'd0, bus.dp_out}, 32'd0);
      chk("rst_async_fd",  {31'd0, bus.frame_done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_frame(100, n);
      chk("restart_latency", n, 32'd8);
      exp_q.push_back(z);
      check_frame(none, none);

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
